demux_latch_1to16: RTL

DEMUX_LATCH_1TO16 -- requirements
Module: demux_latch_1to16

---
 rtl/demux_latch_1to16.sv | 113 +++++++++++
 1 files changed

// File: rtl/demux_latch_1to16.sv
// 1-to-16 demultiplexing latch bank with direct addressed writes and a 16-bit serial scan fill.
// Optional macro DEMUX_DECODE_EN adds the active-low 4-to-16 address decoder output dec_n.
module demux_latch_1to16 #(
  parameter int SCAN_DIR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        g_n,
  input  logic        clr,
  input  logic [3:0]  sel,
  input  logic        d,
  input  logic        wr,
  input  logic        scan_start,
  input  logic        scan_din,
  output logic        busy,
  output logic        done,
  output logic [15:0] y_n
`ifdef DEMUX_DECODE_EN
  ,
  output logic [15:0] dec_n
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_FIRST = (SCAN_DIR != 0) ? 4'd15 : 4'd0;
  localparam logic [3:0] CNT_LAST  = (SCAN_DIR != 0) ? 4'd0  : 4'd15;
  // Adding 4'hF is a modulo-16 decrement, so one adder serves both scan orders.
  localparam logic [3:0] CNT_STEP  = (SCAN_DIR != 0) ? 4'hF  : 4'h1;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] lat_reg, lat_next;

  logic        wr_en;
  logic [3:0]  wr_idx;
  logic        wr_bit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_en      = 1'b0;
    wr_idx     = sel;
    wr_bit     = d;
    if (!g_n) begin
      case (state_reg)
        S_IDLE: begin
          if (scan_start) begin
            state_next = S_SHIFT;
            cnt_next   = CNT_FIRST;
          end else if (wr) begin
            wr_en = 1'b1;
          end
        end
        S_SHIFT: begin
          wr_en  = 1'b1;
          wr_idx = cnt_reg;
          wr_bit = scan_din;
          if (cnt_reg == CNT_LAST) begin
            state_next = S_DONE;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt_reg + CNT_STEP;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  // One write port shared by direct writes and the scan sequencer.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lat_bit
      assign lat_next[gi] = (wr_en && (wr_idx == 4'(gi))) ? wr_bit : lat_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      lat_reg   <= 16'h0000;
    end else if (clr) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      lat_reg   <= 16'h0000;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lat_reg   <= lat_next;
    end
  end

  assign busy = (state_reg == S_SHIFT);
  // A frozen DONE state must not stretch the pulse across disabled cycles.
  assign done = (state_reg == S_DONE) && !g_n;
  assign y_n  = g_n ? 16'hFFFF : ~lat_reg;

`ifdef DEMUX_DECODE_EN
  assign dec_n = g_n ? 16'hFFFF : ~(16'h0001 << sel);
`endif

endmodule
